// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, control-FSM state codes and the select
// encodings used by the controller, the immediate extender and the ALU.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_JAL      = 4'd9;
  localparam state_t S_BEQ      = 4'd10;
  localparam state_t S_HALT     = 4'd11;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// ALU decoder: maps the controller's aluop plus funct fields to alucontrol.
module rv_alu_dec
  import rv_pkg::*;
#(
  parameter int ALUCW = 3
) (
  input  logic [1:0]       aluop,
  input  logic [2:0]       funct3,
  input  logic             op5,
  input  logic             funct7b5,
  output logic [ALUCW-1:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // funct7b5 only selects sub for register-register ops; addi ignores it
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multicycle RV32I control FSM. Optional illegal-opcode trap (HALT state and
// 'illegal' output) is enabled by defining RV_MC_CTRL_ILLEGAL_TRAP_EN.
module rv_mc_ctrl
  import rv_pkg::*;
#(
  parameter int OPW   = 7,
  parameter int ALUCW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             adrsrc,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic [1:0]       resultsrc,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       immsrc,
  output logic [ALUCW-1:0] alucontrol,
  output logic [3:0]       state_dbg
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  // Memory handshake: an access issued in FETCH, MEMREAD or MEMWRITE holds its
  // address/enables steady and the FSM stays put until mem_ready is sampled
  // high on a rising edge; that edge completes the access.
  state_t     state, state_n;
  logic [1:0] aluop;
  logic       pcupdate, branch, irwrite_i, regwrite_i, memwrite_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH: state_n = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_RTYPE:          state_n = S_EXECUTER;
          OP_ITYPE:          state_n = S_EXECUTEI;
          OP_JAL:            state_n = S_JAL;
          OP_BRANCH:         state_n = S_BEQ;
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
          default:           state_n = S_HALT;
`else
          default:           state_n = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_n = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE: state_n = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_n = S_ALUWB;
      S_EXECUTEI: state_n = S_ALUWB;
      S_ALUWB:    state_n = S_FETCH;
      S_JAL:      state_n = S_ALUWB;
      S_BEQ:      state_n = S_FETCH;
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
      S_HALT:     state_n = S_HALT;
`endif
      default:    state_n = S_FETCH;
    endcase
  end

  always_comb begin
    adrsrc     = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    irwrite_i  = 1'b0;
    regwrite_i = 1'b0;
    memwrite_i = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb   = SRCB_4;
        resultsrc = RES_ALU;
        irwrite_i = mem_ready;
        pcupdate  = mem_ready;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc  = RES_DATA;
        regwrite_i = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_i = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNC;
      end
      S_EXECUTEI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNC;
      end
      S_ALUWB: regwrite_i = 1'b1;
      S_JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_4;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  rv_alu_dec #(.ALUCW(ALUCW)) u_alu_dec (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

  // Write enables are masked by reset itself so nothing fires while it is held.
  assign pcwrite   = (pcupdate | (branch & zero)) & ~reset;
  assign irwrite   = irwrite_i  & ~reset;
  assign regwrite  = regwrite_i & ~reset;
  assign memwrite  = memwrite_i & ~reset;
  assign immsrc    = imm_sel(op);
  assign state_dbg = state;

`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state == S_HALT);
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed self-checking bench for the multicycle RV32I control FSM.
module tb_rv_mc_ctrl;
  import rv_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .alucontrol(alucontrol), .state_dbg(state_dbg)
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  // Observed control word: state, enables, selects, alucontrol.
  logic [19:0] obs;
  assign obs = {state_dbg, pcwrite, adrsrc, memwrite, irwrite, regwrite,
                resultsrc, alusrca, alusrcb, immsrc, alucontrol};

  function automatic logic [19:0] ev(input logic [3:0] s, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic rw,
      input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
      input logic [1:0] im, input logic [2:0] al);
    ev = {s, pcw, adr, mw, irw, rw, rs, a, b, im, al};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] e_rst;
    e_rst = ev(S_FETCH, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    reset = 1; mem_ready = 1; op = OP_LOAD; zero = 0; funct3 = 0; funct7b5 = 0;
    repeat (2) tick();
    #1;
    if (obs !== e_rst) begin $display("FAIL reset_hold got %h want %h", obs, e_rst); errors++; end
    checks++;
    tick();
    reset = 0;
    #1;
    if (obs !== ev(S_FETCH, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000)) begin
      $display("FAIL reset_release got %h", obs); errors++;
    end
    checks++;
    tick();
    #1;
    if (state_dbg !== S_DECODE) begin $display("FAIL reach_decode got %0d want %0d", state_dbg, S_DECODE); errors++; end
    checks++;
    reset = 1;
    #1;
    if (obs !== e_rst) begin $display("FAIL reset_mid_decode got %h want %h", obs, e_rst); errors++; end
    checks++;
    tick();
    #1;
    if (obs !== e_rst) begin $display("FAIL reset_held got %h want %h", obs, e_rst); errors++; end
    checks++;
    reset = 0;
    #1;
    if (irwrite !== 1'b1 || alusrcb !== 2'b10 || state_dbg !== S_FETCH) begin
      $display("FAIL after_release irwrite %b alusrcb %b state %0d want 1 10 0", irwrite, alusrcb, state_dbg);
      errors++;
    end
    checks++;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_lw();
    logic [19:0] e [5];
    e[0] = ev(S_FETCH,   1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    e[1] = ev(S_DECODE,  0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    e[2] = ev(S_MEMADR,  0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    e[3] = ev(S_MEMREAD, 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    e[4] = ev(S_MEMWB,   0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    op = OP_LOAD; mem_ready = 1; zero = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (obs !== e[i]) begin $display("FAIL lw cyc%0d got %h want %h", i, obs, e[i]); errors++; end
      checks++;
      tick();
    end
    if (state_dbg !== S_FETCH) begin $display("FAIL lw_end state %0d want 0", state_dbg); errors++; end
    checks++;
  endtask

  task automatic test_sw_stall();
    logic [19:0] e [6];
    logic        mr [6];
    e[0] = ev(S_FETCH,    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    e[1] = ev(S_DECODE,   0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000);
    e[2] = ev(S_MEMADR,   0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    e[3] = ev(S_MEMWRITE, 0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    e[4] = e[3];
    e[5] = e[3];
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    op = OP_STORE; zero = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      #1;
      if (obs !== e[i]) begin $display("FAIL sw cyc%0d got %h want %h", i, obs, e[i]); errors++; end
      checks++;
      tick();
    end
    if (state_dbg !== S_FETCH || memwrite !== 1'b0) begin
      $display("FAIL sw_end state %0d memwrite %b want 0 0", state_dbg, memwrite); errors++;
    end
    checks++;
  endtask

  task automatic test_beq();
    logic [19:0] e [6];
    logic        zr [6];
    e[0] = ev(S_FETCH,  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
    e[1] = ev(S_DECODE, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
    e[2] = ev(S_BEQ,    1,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    e[3] = e[0];
    e[4] = e[1];
    e[5] = ev(S_BEQ,    0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    zr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    op = OP_BRANCH; mem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      zero = zr[i];
      #1;
      if (obs !== e[i]) begin $display("FAIL beq cyc%0d got %h want %h", i, obs, e[i]); errors++; end
      checks++;
      tick();
    end
    zero = 0;
    if (state_dbg !== S_FETCH) begin $display("FAIL beq_end state %0d want 0", state_dbg); errors++; end
    checks++;
  endtask

  task automatic test_alu_decode();
    logic [2:0] f3 [6];
    logic       f7 [6];
    logic [2:0] want [6];
    f3   = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001};
    f7   = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
    want = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000};
    op = OP_RTYPE; mem_ready = 1; zero = 0; funct3 = 3'b000; funct7b5 = 1;
    repeat (2) tick();
    #1;
    if (obs !== ev(S_EXECUTER, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001)) begin
      $display("FAIL rtype_sub got %h", obs); errors++;
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      funct3 = f3[i]; funct7b5 = f7[i];
      #1;
      if (alucontrol !== want[i]) begin
        $display("FAIL rtype_f3_%b_f7_%b got %b want %b", f3[i], f7[i], alucontrol, want[i]); errors++;
      end
      checks++;
    end
    tick();
    #1;
    if (obs !== ev(S_ALUWB, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000)) begin
      $display("FAIL rtype_aluwb got %h", obs); errors++;
    end
    checks++;
    tick();
    op = OP_ITYPE; funct3 = 3'b000; funct7b5 = 1;
    repeat (2) tick();
    #1;
    if (obs !== ev(S_EXECUTEI, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000)) begin
      $display("FAIL addi_f7 got %h", obs); errors++;
    end
    checks++;
    repeat (2) tick();
    funct7b5 = 0;
    if (state_dbg !== S_FETCH) begin $display("FAIL addi_end state %0d want 0", state_dbg); errors++; end
    checks++;
  endtask

  task automatic test_jal();
    logic [19:0] e [4];
    e[0] = ev(S_FETCH,  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000);
    e[1] = ev(S_DECODE, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000);
    e[2] = ev(S_JAL,    1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
    e[3] = ev(S_ALUWB,  0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
    op = OP_JAL; mem_ready = 1; zero = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (obs !== e[i]) begin $display("FAIL jal cyc%0d got %h want %h", i, obs, e[i]); errors++; end
      checks++;
      tick();
    end
    if (state_dbg !== S_FETCH) begin $display("FAIL jal_end state %0d want 0", state_dbg); errors++; end
    checks++;
  endtask

  task automatic test_illegal();
    op = 7'b1111111; mem_ready = 1; zero = 0;
    tick();
    #1;
    if (obs !== ev(S_DECODE, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000)) begin
      $display("FAIL illegal_decode got %h", obs); errors++;
    end
    checks++;
    tick();
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      if (obs !== ev(S_HALT, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000) || illegal !== 1'b1) begin
        $display("FAIL halt cyc%0d got %h illegal %b want %h 1", i, obs,
                 illegal, ev(S_HALT, 0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        errors++;
      end
      checks++;
      tick();
    end
    reset = 1;
    #1;
    if (state_dbg !== S_FETCH || illegal !== 1'b0) begin
      $display("FAIL halt_reset state %0d illegal %b want 0 0", state_dbg, illegal); errors++;
    end
    checks++;
    tick();
    reset = 0;
`else
    #1;
    if (obs !== ev(S_FETCH, 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000)) begin
      $display("FAIL illegal_nop got %h", obs); errors++;
    end
    checks++;
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_alu_decode();
    test_jal();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
